// File: rtl/layer_weight_loader.sv
// Streams neuron-major weight words from a valid/ready source into a layer.
// Ports: clk_i, rst_ni (sync, active low), start_i, abort_i, hold_i, word_* in; write_weight_o, sels, bus, busy_o, done_o out.
module layer_weight_loader #(
  parameter int INPUTS  = 400,
  parameter int NEURONS = 15,
  localparam int NW = (NEURONS > 1) ? $clog2(NEURONS) : 1,
  localparam int WW = (INPUTS > 0) ? $clog2(INPUTS + 1) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          hold_i,
  input  logic          word_valid_i,
  input  logic [63:0]   word_data_i,
  output logic          word_ready_o,
  output logic          write_weight_o,
  output logic [NW-1:0] neuron_sel_o,
  output logic [WW-1:0] weight_sel_o,
  output logic [63:0]   weight_bus_o,
  output logic          busy_o,
  output logic          done_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  localparam logic [WW-1:0] W_LAST = WW'(INPUTS);
  localparam logic [NW-1:0] N_LAST = NW'(NEURONS - 1);

  state_t        state_q, state_d;
  logic [NW-1:0] n_cnt_q, n_cnt_d;
  logic [WW-1:0] w_cnt_q, w_cnt_d;
  logic          wr_q, wr_d;
  logic [NW-1:0] nsel_q, nsel_d;
  logic [WW-1:0] wsel_q, wsel_d;
  logic [63:0]   bus_q, bus_d;
  logic          accept;

  // abort and hold both block the handshake so an aborting cycle never accepts
  assign word_ready_o   = (state_q == LOAD) && !hold_i && !abort_i;
  assign accept         = word_valid_i && word_ready_o;
  assign write_weight_o = wr_q;
  assign neuron_sel_o   = nsel_q;
  assign weight_sel_o   = wsel_q;
  assign weight_bus_o   = bus_q;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    n_cnt_d = n_cnt_q;
    w_cnt_d = w_cnt_q;
    wr_d    = 1'b0;
    nsel_d  = nsel_q;
    wsel_d  = wsel_q;
    bus_d   = bus_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          n_cnt_d = '0;
          w_cnt_d = '0;
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (accept) begin
          wr_d   = 1'b1;
          nsel_d = n_cnt_q;
          wsel_d = w_cnt_q;
          bus_d  = word_data_i;
          if (n_cnt_q == N_LAST && w_cnt_q == W_LAST) begin
            state_d = DRAIN;
          end else if (w_cnt_q == W_LAST) begin
            w_cnt_d = '0;
            n_cnt_d = n_cnt_q + NW'(1);
          end else begin
            w_cnt_d = w_cnt_q + WW'(1);
          end
        end
      end
      // final write is on the outputs during this state
      DRAIN: state_d = abort_i ? IDLE : DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      n_cnt_q <= '0;
      w_cnt_q <= '0;
      wr_q    <= 1'b0;
      nsel_q  <= '0;
      wsel_q  <= '0;
      bus_q   <= '0;
    end else begin
      state_q <= state_d;
      n_cnt_q <= n_cnt_d;
      w_cnt_q <= w_cnt_d;
      wr_q    <= wr_d;
      nsel_q  <= nsel_d;
      wsel_q  <= wsel_d;
      bus_q   <= bus_d;
    end
  end

endmodule

// File: tb/tb_layer_weight_loader.sv
// Self-checking bench for layer_weight_loader with INPUTS=3, NEURONS=2.
// Table-driven load plus scoreboarded corner-case sequences.
module tb_layer_weight_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, hold, word_valid;
  logic [63:0] word_data;
  logic        word_ready, write_weight, busy, done;
  logic [0:0]  neuron_sel;
  logic [1:0]  weight_sel;
  logic [63:0] weight_bus;

  always #5 clk = ~clk;

  layer_weight_loader #(.INPUTS(3), .NEURONS(2)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .abort_i(abort),
    .hold_i(hold),
    .word_valid_i(word_valid),
    .word_data_i(word_data),
    .word_ready_o(word_ready),
    .write_weight_o(write_weight),
    .neuron_sel_o(neuron_sel),
    .weight_sel_o(weight_sel),
    .weight_bus_o(weight_bus),
    .busy_o(busy),
    .done_o(done)
  );

  typedef enum int {M_IDLE, M_LOAD, M_DRAIN, M_DONE} mst_t;
  typedef struct {
    int          n;
    int          w;
    logic [63:0] bus;
  } wr_t;
  typedef struct {
    int          st, ab, hd, v;
    logic [63:0] d;
    int          rdy, wr, bsy, dn;
    int          n, w;
    logic [63:0] bus;
  } vec_t;

  int   checks = 0;
  int   fails = 0;
  mst_t ms = M_IDLE;
  int   mn = 0, mw = 0, m_acc = 0;
  int   m_wr = 0;
  int   wr_seen = 0, done_seen = 0;
  wr_t  m_last = '{0, 0, 64'h0};
  wr_t  q[$];
  vec_t tbl[12];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check();
    wr_t e;
    chk("ready", 64'(word_ready),
        64'(ms == M_LOAD && !hold && !abort));
    chk("busy", 64'(busy), 64'(ms != M_IDLE));
    chk("done", 64'(done), 64'(ms == M_DONE));
    chk("write", 64'(write_weight), 64'(m_wr));
    if (done) done_seen++;
    if (write_weight) wr_seen++;
    if (m_wr != 0 && q.size() > 0) begin
      e = q.pop_front();
      m_last = e;
    end
    chk("neuron_sel", 64'(neuron_sel), 64'(m_last.n));
    chk("weight_sel", 64'(weight_sel), 64'(m_last.w));
    chk("weight_bus", weight_bus, m_last.bus);
  endtask

  task automatic model_update();
    m_wr = 0;
    if (!rst_n) begin
      ms = M_IDLE;
      mn = 0;
      mw = 0;
      q.delete();
      m_last = '{0, 0, 64'h0};
    end else begin
      case (ms)
        M_IDLE: if (start) begin
          ms = M_LOAD;
          mn = 0;
          mw = 0;
          m_acc = 0;
        end
        M_LOAD: begin
          if (abort) ms = M_IDLE;
          else if (word_valid && !hold) begin
            q.push_back('{mn, mw, word_data});
            m_wr = 1;
            m_acc++;
            if (mn == 1 && mw == 3) ms = M_DRAIN;
            else if (mw == 3) begin
              mw = 0;
              mn++;
            end else mw++;
          end
        end
        M_DRAIN: ms = abort ? M_IDLE : M_DONE;
        default: ms = M_IDLE;
      endcase
    end
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic load_words(input logic [63:0] base);
    for (int c = 0; c < 100 && ms != M_IDLE; c++) begin
      word_valid = 1'b1;
      word_data = base + 64'(m_acc);
      step();
    end
    word_valid = 1'b0;
    chk("load_timeout", 64'(ms == M_IDLE), 64'd1);
  endtask

  initial begin
    int wb, db;
    tbl[0]  = '{1, 0, 0, 0, 64'h0,  0, 0, 0, 0, 0, 0, 64'h0};
    tbl[1]  = '{0, 0, 0, 1, 64'h10, 1, 0, 1, 0, 0, 0, 64'h0};
    tbl[2]  = '{0, 0, 0, 1, 64'h11, 1, 1, 1, 0, 0, 0, 64'h10};
    tbl[3]  = '{0, 0, 0, 1, 64'h12, 1, 1, 1, 0, 0, 1, 64'h11};
    tbl[4]  = '{0, 0, 0, 1, 64'h13, 1, 1, 1, 0, 0, 2, 64'h12};
    tbl[5]  = '{0, 0, 0, 1, 64'h14, 1, 1, 1, 0, 0, 3, 64'h13};
    tbl[6]  = '{0, 0, 0, 1, 64'h15, 1, 1, 1, 0, 1, 0, 64'h14};
    tbl[7]  = '{0, 0, 0, 1, 64'h16, 1, 1, 1, 0, 1, 1, 64'h15};
    tbl[8]  = '{0, 0, 0, 1, 64'h17, 1, 1, 1, 0, 1, 2, 64'h16};
    tbl[9]  = '{0, 0, 0, 0, 64'h0,  0, 1, 1, 0, 1, 3, 64'h17};
    tbl[10] = '{1, 0, 0, 0, 64'h0,  0, 0, 1, 1, 1, 3, 64'h17};
    tbl[11] = '{0, 0, 0, 0, 64'h0,  0, 0, 0, 0, 1, 3, 64'h17};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    hold = 1'b0;
    word_valid = 1'b1;
    word_data = 64'hdead;
    @(posedge clk);
    #1;
    // reset then idle with a word offered
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("rst_writes", 64'(wr_seen), 64'd0);
    word_valid = 1'b0;

    // back-to-back load from the table
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st != 0;
      abort = tbl[i].ab != 0;
      hold = tbl[i].hd != 0;
      word_valid = tbl[i].v != 0;
      word_data = tbl[i].d;
      @(negedge clk);
      check();
      chk($sformatf("v%0d_ready", i), 64'(word_ready), 64'(tbl[i].rdy));
      chk($sformatf("v%0d_write", i), 64'(write_weight), 64'(tbl[i].wr));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(tbl[i].bsy));
      chk($sformatf("v%0d_done", i), 64'(done), 64'(tbl[i].dn));
      chk($sformatf("v%0d_n", i), 64'(neuron_sel), 64'(tbl[i].n));
      chk($sformatf("v%0d_w", i), 64'(weight_sel), 64'(tbl[i].w));
      chk($sformatf("v%0d_bus", i), weight_bus, tbl[i].bus);
      @(posedge clk);
      model_update();
      #1;
    end
    start = 1'b0;

    // bubbles and a 3-cycle hold mid-stream
    wb = wr_seen;
    db = done_seen;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 200 && ms != M_IDLE; c++) begin
      hold = (c >= 4 && c < 7);
      word_valid = 1'($urandom_range(0, 1));
      word_data = 64'h20 + 64'(m_acc);
      step();
    end
    hold = 1'b0;
    word_valid = 1'b0;
    chk("bub_idle", 64'(ms == M_IDLE), 64'd1);
    chk("bub_writes", 64'(wr_seen - wb), 64'd8);
    chk("bub_done", 64'(done_seen - db), 64'd1);

    // abort after 5 accepts, then restart from (0,0)
    wb = wr_seen;
    db = done_seen;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 50 && m_acc < 5; c++) begin
      word_valid = 1'b1;
      word_data = 64'h30 + 64'(m_acc);
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    word_valid = 1'b0;
    step();
    chk("abort_busy", 64'(busy), 64'd0);
    step();
    chk("abort_writes", 64'(wr_seen - wb), 64'd5);
    chk("abort_done", 64'(done_seen - db), 64'd0);
    wb = wr_seen;
    start = 1'b1;
    step();
    start = 1'b0;
    load_words(64'h40);
    step();
    chk("restart_writes", 64'(wr_seen - wb), 64'd8);

    // reset after 3 accepts
    wb = wr_seen;
    db = done_seen;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 50 && m_acc < 3; c++) begin
      word_valid = 1'b1;
      word_data = 64'h50 + 64'(m_acc);
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("rst_mid_bus", weight_bus, 64'h0);
    step();
    step();
    word_valid = 1'b0;
    chk("rst_mid_writes", 64'(wr_seen - wb), 64'd3);
    chk("rst_mid_done", 64'(done_seen - db), 64'd0);

    // start pulsed during LOAD and during DONE is ignored
    wb = wr_seen;
    db = done_seen;
    start = 1'b1;
    step();
    for (int c = 0; c < 100 && ms != M_IDLE; c++) begin
      start = (ms == M_LOAD && m_acc == 4) || (ms == M_DONE);
      word_valid = 1'b1;
      word_data = 64'h60 + 64'(m_acc);
      step();
    end
    start = 1'b0;
    word_valid = 1'b0;
    step();
    chk("ign_busy", 64'(busy), 64'd0);
    chk("ign_writes", 64'(wr_seen - wb), 64'd8);
    chk("ign_done", 64'(done_seen - db), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
